// File: rtl/time_entry_if.sv
// Keypad-side bus of the time entry controller: keypad/button inputs and
// the new-time digits, load strobes and status flags it produces.
interface time_entry_if;
  localparam int unsigned DIGIT_W = 4;

  logic               one_second;
  logic [DIGIT_W-1:0] key;
  logic               key_valid;
  logic               time_button;
  logic               alarm_button;
  logic [DIGIT_W-1:0] key_buffer_ms_hr;
  logic [DIGIT_W-1:0] key_buffer_ls_hr;
  logic [DIGIT_W-1:0] key_buffer_ms_min;
  logic [DIGIT_W-1:0] key_buffer_ls_min;
  logic               load_new_c;
  logic               load_new_a;
  logic               show_new_time;
  logic               entry_error;

  modport master (
    output one_second, key, key_valid, time_button, alarm_button,
    input  key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min,
    input  load_new_c, load_new_a, show_new_time, entry_error
  );

  modport slave (
    input  one_second, key, key_valid, time_button, alarm_button,
    output key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min,
    output load_new_c, load_new_a, show_new_time, entry_error
  );
endinterface

// File: rtl/time_entry_ctrl.sv
// Keypad front end: shifts digits into an HH:MM buffer, range-checks on commit
// and strobes the time counter or alarm register. `TIMEOUT_EN adds the idle timeout.
module time_entry_ctrl #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input logic         clk,
  input logic         reset,
  time_entry_if.slave bus
);
  localparam int unsigned DW = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD_C, LOAD_A} state_e;

  state_e              state_q, state_d;
  logic [3:0][DW-1:0]  buf_q, buf_d;   // [3]=ms_hr .. [0]=ls_min
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                load_c_q, load_c_d;
  logic                load_a_q, load_a_d;
  logic                show_q, show_d;
  logic                err_q, err_d;
  logic                tmo_clr_c, tmo_inc_c, expire_c;
  logic                digit_c, valid_c;

  assign digit_c = bus.key_valid && (bus.key <= DW'(9));

  // Commit range check: HH in 00..23, MM in 00..59, all four digits entered
  assign valid_c = (cnt_q == CW'(4)) && (buf_q[3] <= DW'(2)) && (buf_q[1] <= DW'(5)) &&
                   (buf_q[0] <= DW'(9)) &&
                   ((buf_q[3] == DW'(2)) ? (buf_q[2] <= DW'(3)) : (buf_q[2] <= DW'(9)));

`ifdef TIMEOUT_EN
  logic [TW-1:0] tmo_q, tmo_d;

  assign expire_c = (tmo_q == TW'(TIMEOUT_SEC));

  always_comb begin
    tmo_d = tmo_q;
    if (tmo_clr_c)
      tmo_d = '0;
    else if (tmo_inc_c && (tmo_q != TW'(TIMEOUT_SEC)))
      tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic unused_tmo_c;

  assign expire_c     = 1'b0;
  assign unused_tmo_c = tmo_clr_c ^ tmo_inc_c ^ bus.one_second ^ (TIMEOUT_SEC == 0);
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    load_c_d  = 1'b0;
    load_a_d  = 1'b0;
    err_d     = 1'b0;
    tmo_clr_c = 1'b0;
    tmo_inc_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (digit_c) begin
          buf_d     = {buf_q[2:0], bus.key};
          cnt_d     = (cnt_q == CW'(4)) ? CW'(4) : cnt_q + CW'(1);
          tmo_clr_c = 1'b1;
          state_d   = ENTRY;
        end
      end
      ENTRY: begin
        if ((bus.time_button && bus.alarm_button) ||
            ((bus.time_button || bus.alarm_button) && !valid_c)) begin
          err_d     = 1'b1;
          buf_d     = '0;
          cnt_d     = '0;
          tmo_clr_c = 1'b1;
          state_d   = IDLE;
        end else if (bus.time_button) begin
          load_c_d = 1'b1;
          state_d  = LOAD_C;
        end else if (bus.alarm_button) begin
          load_a_d = 1'b1;
          state_d  = LOAD_A;
        end else if (expire_c) begin
          buf_d     = '0;
          cnt_d     = '0;
          tmo_clr_c = 1'b1;
          state_d   = IDLE;
        end else if (digit_c) begin
          buf_d     = {buf_q[2:0], bus.key};
          cnt_d     = (cnt_q == CW'(4)) ? CW'(4) : cnt_q + CW'(1);
          tmo_clr_c = 1'b1;
        end else if (bus.one_second) begin
          tmo_inc_c = 1'b1;
        end
      end
      LOAD_C, LOAD_A: begin
        buf_d     = '0;
        cnt_d     = '0;
        tmo_clr_c = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    show_d = (state_d == ENTRY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      load_c_q <= 1'b0;
      load_a_q <= 1'b0;
      show_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      load_c_q <= load_c_d;
      load_a_q <= load_a_d;
      show_q   <= show_d;
      err_q    <= err_d;
    end
  end

  assign bus.key_buffer_ms_hr  = buf_q[3];
  assign bus.key_buffer_ls_hr  = buf_q[2];
  assign bus.key_buffer_ms_min = buf_q[1];
  assign bus.key_buffer_ls_min = buf_q[0];
  assign bus.load_new_c        = load_c_q;
  assign bus.load_new_a        = load_a_q;
  assign bus.show_new_time     = show_q;
  assign bus.entry_error       = err_q;
endmodule

// File: tb/tb_time_entry_ctrl.sv
// Self-checking bench for time_entry_ctrl: directed keypad scenarios plus
// random keypad traffic, compared cycle by cycle against a queue-based model.
module tb_time_entry_ctrl;
  localparam int unsigned TSEC = 3;
`ifdef TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_LC    = 2;
  localparam int M_LA    = 3;

  logic clk;
  logic reset;
  time_entry_if te_bus ();

  time_entry_ctrl #(.TIMEOUT_SEC(TSEC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (te_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: digits entered so far (oldest first), mode, idle seconds
  int q[$];
  int m_st;
  int secs;
  bit m_err;

  bit i_kv, i_tb, i_ab, i_sec;
  int i_key;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit time_ok();
    int hh, mm;
    if (q.size() != 4) return 1'b0;
    hh = q[0] * 10 + q[1];
    mm = q[2] * 10 + q[3];
    return (hh <= 23) && (mm <= 59);
  endfunction

  function automatic logic [15:0] exp_buf();
    logic [15:0] b = '0;
    foreach (q[i]) b = {b[11:0], 4'(q[i])};
    return b;
  endfunction

  task automatic model_reset();
    q.delete();
    m_st  = M_IDLE;
    secs  = 0;
    m_err = 1'b0;
  endtask

  task automatic model_step();
    m_err = 1'b0;
    if (m_st == M_LC || m_st == M_LA) begin
      q.delete();
      m_st = M_IDLE;
    end else if (m_st == M_ENTRY && (i_tb || i_ab)) begin
      if ((i_tb && i_ab) || !time_ok()) begin
        m_err = 1'b1;
        q.delete();
        m_st = M_IDLE;
      end else begin
        m_st = i_tb ? M_LC : M_LA;
      end
    end else if (m_st == M_ENTRY && TMO && secs >= int'(TSEC)) begin
      q.delete();
      m_st = M_IDLE;
    end else if (i_kv && i_key <= 9) begin
      q.push_back(i_key);
      if (q.size() > 4) void'(q.pop_front());
      secs = 0;
      m_st = M_ENTRY;
    end else if (m_st == M_ENTRY && i_sec && secs < int'(TSEC)) begin
      secs++;
    end
  endtask

  task automatic compare_all(input string ctx);
    logic [15:0] obs_buf;
    obs_buf = {te_bus.key_buffer_ms_hr, te_bus.key_buffer_ls_hr,
               te_bus.key_buffer_ms_min, te_bus.key_buffer_ls_min};
    check({ctx, ".buf"},   32'(obs_buf),              32'(exp_buf()));
    check({ctx, ".ld_c"},  32'(te_bus.load_new_c),    32'(m_st == M_LC));
    check({ctx, ".ld_a"},  32'(te_bus.load_new_a),    32'(m_st == M_LA));
    check({ctx, ".show"},  32'(te_bus.show_new_time), 32'(m_st == M_ENTRY));
    check({ctx, ".err"},   32'(te_bus.entry_error),   32'(m_err));
  endtask

  task automatic step(input string ctx, input bit kv, input int k,
                      input bit tb, input bit ab, input bit sec);
    @(negedge clk);
    i_kv = kv; i_key = k; i_tb = tb; i_ab = ab; i_sec = sec;
    te_bus.key_valid    = kv;
    te_bus.key          = 4'(k);
    te_bus.time_button  = tb;
    te_bus.alarm_button = ab;
    te_bus.one_second   = sec;
    @(posedge clk);
    model_step();
    #1;
    compare_all(ctx);
  endtask

  task automatic key(input string ctx, input int k);
    step(ctx, 1'b1, k, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input string ctx, input int n);
    for (int i = 0; i < n; i++) step(ctx, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter4(input string ctx, input int a, input int b, input int c, input int d);
    key(ctx, a); key(ctx, b); key(ctx, c); key(ctx, d);
  endtask

  task automatic zero_inputs();
    i_kv = 0; i_key = 0; i_tb = 0; i_ab = 0; i_sec = 0;
    te_bus.key_valid    = 1'b0;
    te_bus.key          = 4'd0;
    te_bus.time_button  = 1'b0;
    te_bus.alarm_button = 1'b0;
    te_bus.one_second   = 1'b0;
  endtask

  initial begin
    zero_inputs();
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 compare_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // Valid time commit: strobe one cycle with digits held, then cleared
    enter4("t1230", 1, 2, 3, 0);
    step("t1230.btn", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("t1230.buf_held", 32'({te_bus.key_buffer_ms_hr, te_bus.key_buffer_ls_hr,
                                 te_bus.key_buffer_ms_min, te_bus.key_buffer_ls_min}), 32'h1230);
    idle("t1230.after", 2);

    // 24:00 is out of range
    enter4("a2400", 2, 4, 0, 0);
    step("a2400.btn", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    check("a2400.err_pulse", 32'(te_bus.entry_error), 32'd1);
    idle("a2400.after", 2);

    // Five digits: oldest falls off, 12:35 to alarm
    enter4("a1235", 9, 1, 2, 3);
    key("a1235", 5);
    step("a1235.btn", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle("a1235.after", 2);

    // Too few digits
    key("short", 1); key("short", 2);
    step("short.btn", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle("short.after", 1);

    // Buttons in idle ignored, non-digit key ignored
    step("idle.btn", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    step("idle.hex", 1'b1, 12, 1'b0, 1'b0, 1'b0);
    idle("idle.after", 1);

    // Timeout after TSEC ticks
    key("tmo", 5);
    for (int i = 0; i < int'(TSEC); i++) begin
      step("tmo.tick", 1'b0, 0, 1'b0, 1'b0, 1'b1);
      idle("tmo.gap", 1);
    end
    idle("tmo.after", 2);

    // Key on the final tick's cycle keeps the entry alive
    key("tmo_key", 5);
    for (int i = 0; i < int'(TSEC) - 1; i++) step("tmo_key.tick", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    step("tmo_key.both", 1'b1, 7, 1'b0, 1'b0, 1'b1);
    idle("tmo_key.after", 2);
    step("tmo_key.exit", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle("tmo_key.exit2", 1);

    // Both buttons together with a valid entry
    enter4("dual", 0, 9, 4, 5);
    step("dual.btn", 1'b0, 0, 1'b1, 1'b1, 1'b0);
    idle("dual.after", 2);

    // Boundary 23:59 valid, then reset cuts the load strobe
    enter4("rst", 2, 3, 5, 9);
    step("rst.btn", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    zero_inputs();
    model_reset();
    #1 compare_all("rst.mid_load");
    @(negedge clk);
    reset = 1'b1;
    idle("rst.after", 1);

    // Random keypad traffic
    for (int n = 0; n < 2000; n++) begin
      int r, k;
      bit kv, tb, ab, sec;
      r   = int'($urandom_range(0, 99));
      kv  = (r < 45);
      k   = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 15));
      tb  = ($urandom_range(0, 99) < 6);
      ab  = ($urandom_range(0, 99) < 6);
      sec = ($urandom_range(0, 99) < 20);
      step("rand", kv, k, tb, ab, sec);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
